mult_rr_scheduler: RTL and testbench
====================================

Name: mult_rr_scheduler

Overview:
- Shares one repeated-addition multiplier unit among NREQ requesters.
- The multiplier has a start/valid interface: operands are sampled on a start pulse, and a one-cycle valid pulse carries the product.
- This block arbitrates round-robin, drives the operands and start pulse, waits for valid under a watchdog, and returns the product to the granted requester with a done pulse.
- It sits between requester blocks and the multiplier; one multiplication is in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 32, operand and result width.
- TIMEOUT, 1024, maximum WAIT cycles before the watchdog aborts a job.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NREQ  per-requester request level.
- req_a  in  NREQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse; operands were captured.
- done  out  NREQ  one-hot, one-cycle pulse; result/err valid this cycle.
- result  out  WIDTH  product of the last completed job; held until the next done.
- err  out  1  high with done when the job timed out.
- mul_in1  out  WIDTH  operand A to multiplier.
- mul_in2  out  WIDTH  operand B to multiplier.
- mul_S  out  1  one-cycle start pulse to multiplier.
- mul_V  in  1  one-cycle product-valid pulse from multiplier.
- mul_data  in  WIDTH  product from multiplier, valid when mul_V=1.

Behaviour:
- Reset (async, reset_n=0): state IDLE; gnt, done, err, mul_S = 0; result, mul_in1, mul_in2 = 0; rr pointer = 0; timer = 0; idx = 0.
- All outputs are registered. States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req==0: stay.
  - Otherwise select the first set bit scanning ptr, ptr+1, ..., wrapping mod NREQ.
  - Next edge: idx<=sel; mul_in1/mul_in2<=that requester's operands; gnt[sel]<=1; mul_S<=1; state->ISSUE.
- ISSUE (exactly 1 cycle): gnt and mul_S are high. Next edge: both <=0; timer<=0; state->WAIT.
- WAIT:
  - mul_V=1: result<=mul_data; done[idx]<=1; err<=0; ->RESP.
  - Else if timer==TIMEOUT-1: result<=0; done[idx]<=1; err<=1; ->RESP.
  - Else timer<=timer+1.
  - mul_V takes priority over timeout on the same edge.
- RESP (exactly 1 cycle): done/err high. Next edge: done, err <=0; ptr<=(idx+1) mod NREQ; ->IDLE.
- mul_in1/mul_in2 hold their values from grant until the next grant.
- mul_V in IDLE, ISSUE or RESP is ignored (stale pulse after reset or timeout).
- Requesters must present stable operands while req=1 and drop req after gnt. A req still high in IDLE is treated as a new request; round-robin order still applies.
- Minimum turnaround: req sampled at edge t; gnt/mul_S during cycle t+1; done no earlier than cycle t+3. Back-to-back grant no earlier than 1 cycle after RESP.
- Fairness: with all req high, grants rotate 0,1,...,NREQ-1,0.
- Operand range: requesters keep min(a,b) below TIMEOUT-4 so the multiplier completes; larger operands produce err.
- Reset mid-job: aborts with no done pulse; the multiplier is not reset by this block.
- No arithmetic is performed here; result is passed through at WIDTH bits.

Test Plan:
- Reset, then req=0001 with a=6, b=7 -> gnt=0001 one cycle with mul_S=1, mul_in1=6, mul_in2=7; model returns 42 -> done=0001, result=42, err=0.
- req=1111 held, all four operand pairs distinct -> grants occur in order 0,1,2,3,0; each done matches its grantee's product; no two gnt bits ever set together.
- Model never asserts mul_V, TIMEOUT=16 -> done[idx]=1 with err=1 and result=0 exactly 16 WAIT cycles after entering WAIT; ptr advances.
- mul_V asserted on the same edge the timer reaches TIMEOUT-1 -> err=0 and result=mul_data.
- Spurious mul_V in IDLE, then req=0100 with a=3, b=5 -> result stays unchanged until the real 15 arrives; done=0100 once.
- reset_n pulsed low during WAIT -> all outputs 0 immediately (asynchronously); late mul_V ignored; the next request is granted from ptr=0.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// mult_rr_scheduler
// Shares one start/valid multiplier among NREQ requesters. Requests are
// served round-robin, one job in flight at a time. A watchdog aborts jobs
// whose product never arrives and reports them with err.
//
// Ports:
//   clock, reset_n     rising-edge clock, asynchronous active-low reset
//   req                per-requester request level
//   req_a, req_b       packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt                one-hot pulse, the requester's operands were captured
//   done               one-hot pulse, result/err are valid this cycle
//   result             product of the last completed job, held until next done
//   err                high together with done when the job timed out
//   mul_in1, mul_in2   operands to the multiplier, held from grant to grant
//   mul_S              one-cycle start pulse to the multiplier
//   mul_V, mul_data    one-cycle product-valid pulse and product from multiplier
module mult_rr_scheduler #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       done,
  output logic [WIDTH-1:0]      result,
  output logic                  err,
  output logic [WIDTH-1:0]      mul_in1,
  output logic [WIDTH-1:0]      mul_in2,
  output logic                  mul_S,
  input  logic                  mul_V,
  input  logic [WIDTH-1:0]      mul_data
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   sel;
  logic            found;
  logic [TW-1:0]   timer;

  // Round-robin pick: scan ptr, ptr+1, ... wrapping at NREQ and take the
  // first requester that is asking. The candidate index is kept one bit
  // wider so the wrap can be done by a single subtraction.
  always_comb begin
    logic [IW:0] cand;
    sel   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ))
        cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found = 1'b1;
        sel   = cand[IW-1:0];
      end
    end
  end

  // Job sequencer: grant and start in one cycle, wait for the product under
  // the watchdog, report for one cycle, then move the pointer past the
  // requester just served. A valid pulse outside WAIT is a leftover from an
  // aborted job and is deliberately ignored.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      gnt     <= '0;
      done    <= '0;
      err     <= 1'b0;
      mul_S   <= 1'b0;
      result  <= '0;
      mul_in1 <= '0;
      mul_in2 <= '0;
      ptr     <= '0;
      idx     <= '0;
      timer   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            idx      <= sel;
            mul_in1  <= req_a[sel*WIDTH +: WIDTH];
            mul_in2  <= req_b[sel*WIDTH +: WIDTH];
            gnt      <= '0;
            gnt[sel] <= 1'b1;
            mul_S    <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          gnt   <= '0;
          mul_S <= 1'b0;
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A product arriving on the timeout edge still wins.
          if (mul_V) begin
            result    <= mul_data;
            done[idx] <= 1'b1;
            err       <= 1'b0;
            state     <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            result    <= '0;
            done[idx] <= 1'b1;
            err       <= 1'b1;
            state     <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          done  <= '0;
          err   <= 1'b0;
          ptr   <= (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// tb_mult_rr_scheduler
// Self-checking bench for mult_rr_scheduler with NREQ=4, WIDTH=32 and a
// short watchdog (TIMEOUT=16). A behavioural multiplier answers each start
// pulse after a programmable latency, can be told to stay silent, and can
// inject a stray valid pulse on demand.
module tb_mult_rr_scheduler;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 16;

  localparam logic [127:0] OPA  = {32'd9, 32'd7, 32'd5, 32'd3};
  localparam logic [127:0] OPB  = {32'd10, 32'd8, 32'd6, 32'd4};
  localparam logic [127:0] OPA0 = {32'd9, 32'd7, 32'd5, 32'd6};
  localparam logic [127:0] OPB0 = {32'd10, 32'd8, 32'd6, 32'd7};
  localparam logic [127:0] OPAX = {32'd9, 32'd7, 32'h0000FFFF, 32'd3};
  localparam logic [127:0] OPBX = {32'd10, 32'd8, 32'h00010001, 32'd4};

  logic              clock;
  logic              reset_n;
  logic [NREQ-1:0]   req;
  logic [127:0]      req_a;
  logic [127:0]      req_b;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [WIDTH-1:0]  result;
  logic              err;
  logic [WIDTH-1:0]  mul_in1;
  logic [WIDTH-1:0]  mul_in2;
  logic              mul_S;
  logic              mul_V;
  logic [WIDTH-1:0]  mul_data;

  int testsRun    = 0;
  int testsFailed = 0;

  int modelLat    = 1;
  bit modelSilent = 1'b0;
  int spurReq     = 0;
  int spurSent    = 0;

  typedef struct {
    bit           doReset;
    logic [3:0]   req;
    logic [127:0] a;
    logic [127:0] b;
    int           lat;
    logic [3:0]   expGnt;
    logic [31:0]  expIn1;
    logic [31:0]  expIn2;
    logic [31:0]  expResult;
    logic         expErr;
    int           expTurn;
  } vec_t;

  vec_t vecs [12];

  logic [3:0]  gGnt;
  logic [3:0]  gDone;
  logic        gS;
  logic        gErr;
  logic [31:0] gIn1;
  logic [31:0] gIn2;
  logic [31:0] gRes;
  int          turn;
  int          badGnt;
  int          earlyRes;

  mult_rr_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .err(err),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_S(mul_S),
    .mul_V(mul_V), .mul_data(mul_data)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural multiplier: sees the start pulse just after an edge,
  // raises valid modelLat edges later for exactly one cycle. A pending
  // stray-pulse request is served first.
  initial begin
    logic [31:0] ma;
    logic [31:0] mb;
    mul_V    = 1'b0;
    mul_data = '0;
    forever begin
      @(posedge clock);
      #1;
      if (spurSent != spurReq) begin
        spurSent = spurReq;
        mul_V    = 1'b1;
        mul_data = 32'd999;
        @(posedge clock);
        #1;
        mul_V = 1'b0;
      end else if (mul_S && !modelSilent) begin
        ma = mul_in1;
        mb = mul_in2;
        repeat (modelLat) @(posedge clock);
        #1;
        mul_V    = 1'b1;
        mul_data = ma * mb;
        @(posedge clock);
        #1;
        mul_V = 1'b0;
      end
    end
  end

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Assert reset away from the clock edge and confirm every output clears
  // without waiting for an edge.
  task automatic applyReset(input string tag);
    @(negedge clock);
    req     = '0;
    reset_n = 1'b0;
    #1;
    checkOutput({tag, " reset ctl"}, 32'({gnt, done, err, mul_S}), 32'd0);
    checkOutput({tag, " reset result"}, result, 32'd0);
    checkOutput({tag, " reset mul_in1"}, mul_in1, 32'd0);
    checkOutput({tag, " reset mul_in2"}, mul_in2, 32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Drive a request and watch until done, recording what the grant and the
  // response looked like. turn counts cycles from gnt to done.
  task automatic runJob(input logic [3:0] r, input bit dropOnGnt, input int maxCyc,
                        input string tag);
    logic [31:0] startRes;
    int          gntCyc;
    bit          seen;
    gGnt = '0; gS = 1'b0; gIn1 = '0; gIn2 = '0;
    gDone = '0; gRes = '0; gErr = 1'b0;
    turn = -1; badGnt = 0; earlyRes = 0; gntCyc = -1; seen = 1'b0;
    startRes = result;
    req = r;
    for (int c = 0; c < maxCyc && !seen; c++) begin
      @(negedge clock);
      if (gnt != '0) begin
        if ($countones(gnt) != 1 || gGnt != '0) badGnt++;
        gGnt   = gnt;
        gS     = mul_S;
        gIn1   = mul_in1;
        gIn2   = mul_in2;
        gntCyc = c;
        if (dropOnGnt) req = '0;
      end
      if (done != '0) begin
        gDone = done;
        gRes  = result;
        gErr  = err;
        turn  = c - gntCyc;
        seen  = 1'b1;
      end else if (result !== startRes) begin
        earlyRes++;
      end
    end
    checkOutput({tag, " finished"}, 32'(seen), 32'd1);
  endtask

  // Apply one table vector and compare every recorded field.
  task automatic applyStimulus(input int i, input vec_t v);
    string t;
    t = $sformatf("v%0d", i);
    if (v.doReset) applyReset(t);
    req_a       = v.a;
    req_b       = v.b;
    modelLat    = v.lat;
    modelSilent = 1'b0;
    runJob(v.req, 1'b0, 64, t);
    checkOutput({t, " gnt"}, 32'(gGnt), 32'(v.expGnt));
    checkOutput({t, " mul_S"}, 32'(gS), 32'd1);
    checkOutput({t, " mul_in1"}, gIn1, v.expIn1);
    checkOutput({t, " mul_in2"}, gIn2, v.expIn2);
    checkOutput({t, " done"}, 32'(gDone), 32'(v.expGnt));
    checkOutput({t, " result"}, gRes, v.expResult);
    checkOutput({t, " err"}, 32'(gErr), 32'(v.expErr));
    checkOutput({t, " turnaround"}, 32'(turn), 32'(v.expTurn));
    checkOutput({t, " one-hot gnt"}, 32'(badGnt), 32'd0);
  endtask

  // Main sequence: table of directed jobs, then hand-written corner cases.
  initial begin
    int dones;
    int moves;
    reset_n = 1'b1;
    req     = '0;
    req_a   = '0;
    req_b   = '0;

    // reset, req, a, b, lat, gnt/done, in1, in2, result, err, turn
    vecs[0]  = '{1'b1, 4'b0001, OPA0, OPB0, 1, 4'b0001, 32'd6, 32'd7, 32'd42, 1'b0, 2};
    vecs[1]  = '{1'b1, 4'b1111, OPA, OPB, 2, 4'b0001, 32'd3, 32'd4, 32'd12, 1'b0, 3};
    vecs[2]  = '{1'b0, 4'b1111, OPA, OPB, 2, 4'b0010, 32'd5, 32'd6, 32'd30, 1'b0, 3};
    vecs[3]  = '{1'b0, 4'b1111, OPA, OPB, 2, 4'b0100, 32'd7, 32'd8, 32'd56, 1'b0, 3};
    vecs[4]  = '{1'b0, 4'b1111, OPA, OPB, 2, 4'b1000, 32'd9, 32'd10, 32'd90, 1'b0, 3};
    vecs[5]  = '{1'b0, 4'b1111, OPA, OPB, 2, 4'b0001, 32'd3, 32'd4, 32'd12, 1'b0, 3};
    vecs[6]  = '{1'b0, 4'b1010, OPA, OPB, 3, 4'b0010, 32'd5, 32'd6, 32'd30, 1'b0, 4};
    vecs[7]  = '{1'b0, 4'b1010, OPA, OPB, 3, 4'b1000, 32'd9, 32'd10, 32'd90, 1'b0, 4};
    vecs[8]  = '{1'b0, 4'b0101, OPA, OPB, 1, 4'b0001, 32'd3, 32'd4, 32'd12, 1'b0, 2};
    vecs[9]  = '{1'b0, 4'b0101, OPA, OPB, 1, 4'b0100, 32'd7, 32'd8, 32'd56, 1'b0, 2};
    vecs[10] = '{1'b0, 4'b0011, OPA, OPB, 1, 4'b0001, 32'd3, 32'd4, 32'd12, 1'b0, 2};
    vecs[11] = '{1'b0, 4'b0010, OPAX, OPBX, 1, 4'b0010, 32'h0000FFFF, 32'h00010001,
                 32'hFFFFFFFF, 1'b0, 2};

    for (int i = 0; i < 12; i++) applyStimulus(i, vecs[i]);
    req = '0;

    // Watchdog: a job that never gets a product reports err after 16 WAIT
    // cycles, and the pointer still moves on.
    applyReset("A");
    req_a = OPA0; req_b = OPB0; modelLat = 1; modelSilent = 1'b0;
    runJob(4'b0001, 1'b1, 64, "A1");
    checkOutput("A1 result", gRes, 32'd42);
    modelSilent = 1'b1;
    runJob(4'b0100, 1'b1, 64, "A2");
    checkOutput("A2 done", 32'(gDone), 32'b0100);
    checkOutput("A2 err", 32'(gErr), 32'd1);
    checkOutput("A2 result", gRes, 32'd0);
    checkOutput("A2 turnaround", 32'(turn), 32'd17);
    modelSilent = 1'b0;
    req_a = OPA; req_b = OPB;
    runJob(4'b0101, 1'b1, 64, "A3");
    checkOutput("A3 gnt after timeout", 32'(gGnt), 32'b0001);
    checkOutput("A3 result", gRes, 32'd12);

    // Product arriving on the timeout edge wins; one cycle later it loses.
    modelLat = 16;
    runJob(4'b0010, 1'b1, 64, "B1");
    checkOutput("B1 gnt", 32'(gGnt), 32'b0010);
    checkOutput("B1 err", 32'(gErr), 32'd0);
    checkOutput("B1 result", gRes, 32'd30);
    checkOutput("B1 turnaround", 32'(turn), 32'd17);
    modelLat = 17;
    runJob(4'b0010, 1'b1, 64, "B2");
    checkOutput("B2 err", 32'(gErr), 32'd1);
    checkOutput("B2 result", gRes, 32'd0);
    checkOutput("B2 turnaround", 32'(turn), 32'd17);
    dones = 0;
    repeat (3) begin
      @(negedge clock);
      if (done != '0) dones++;
    end
    checkOutput("B2 stale valid done", 32'(dones), 32'd0);
    checkOutput("B2 stale valid result", result, 32'd0);

    // Stray valid while idle must not touch result or produce done.
    req = '0;
    spurReq++;
    dones = 0;
    moves = 0;
    repeat (5) begin
      @(negedge clock);
      if (done != '0) dones++;
      if (result !== 32'd0) moves++;
    end
    checkOutput("C stray done", 32'(dones), 32'd0);
    checkOutput("C stray result", 32'(moves), 32'd0);
    req_a = {32'd9, 32'd3, 32'd5, 32'd3};
    req_b = {32'd10, 32'd5, 32'd6, 32'd4};
    modelLat = 2;
    runJob(4'b0100, 1'b1, 64, "C");
    checkOutput("C gnt", 32'(gGnt), 32'b0100);
    checkOutput("C done", 32'(gDone), 32'b0100);
    checkOutput("C result", gRes, 32'd15);
    checkOutput("C result held early", 32'(earlyRes), 32'd0);
    dones = 0;
    repeat (8) begin
      @(negedge clock);
      if (done != '0) dones++;
    end
    checkOutput("C single done", 32'(dones), 32'd0);

    // Reset in the middle of WAIT: outputs clear at once, the late product
    // is ignored, and arbitration restarts from requester 0.
    req_a = OPA; req_b = OPB; modelLat = 6;
    req = 4'b0010;
    gGnt = '0;
    for (int c = 0; c < 10 && gGnt == '0; c++) begin
      @(negedge clock);
      gGnt = gnt;
    end
    req = '0;
    checkOutput("D gnt", 32'(gGnt), 32'b0010);
    repeat (2) @(negedge clock);
    applyReset("D");
    dones = 0;
    repeat (10) begin
      @(negedge clock);
      if (done != '0) dones++;
    end
    checkOutput("D late valid done", 32'(dones), 32'd0);
    checkOutput("D late valid result", result, 32'd0);
    modelLat = 1;
    runJob(4'b1001, 1'b1, 64, "D2");
    checkOutput("D2 gnt from ptr 0", 32'(gGnt), 32'b0001);
    checkOutput("D2 result", gRes, 32'd12);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
